// File: rtl/mds_pkg.sv
// Shared types and constants for the bit-serial MDS matrix-vector multiplier
// over GF(2)[x]/(x^8+x^2+1).
package mds_pkg;

    typedef logic [7:0] elem_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam elem_t RED = 8'h05;

    // circulant(2,3,1,1); M[i][j] lives at bits [8*(4*i+j)+:8]
    localparam logic [127:0] DEFAULT_MATRIX = 128'h02010103_03020101_01030201_01010302;

endpackage

// File: rtl/mul2.sv
// Multiply-by-x in GF(2)[x]/(x^8+x^2+1): shift left, fold bit 8 back as x^2+1.
module mul2
    import mds_pkg::*;
(
    input  elem_t a,
    output elem_t y
);

    // doubling with conditional reduction
    always_comb begin
        if (a[7]) begin
            y = {a[6:0], 1'b0} ^ RED;
        end else begin
            y = {a[6:0], 1'b0};
        end
    end

endmodule

// File: rtl/mds_serial_mix.sv
// Bit-serial 4x4 matrix-vector multiply: one Horner step (double, then add the
// columns selected by coefficient bit cnt) per row per cycle, MSB first.
module mds_serial_mix
    import mds_pkg::*;
#(
    parameter logic [127:0] MATRIX = DEFAULT_MATRIX
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    state_t      state_r;
    state_t      state_next_s;
    elem_t [3:0] x_r;
    elem_t [3:0] acc_r;
    elem_t [3:0] nxt_s;
    logic  [2:0] cnt_r;
    logic        accept_s;
    logic        step_s;
    logic        in_ready_r;
    logic        out_valid_r;

    // Next-state and datapath control decode
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        step_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (cnt_r == 3'd0) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register; handshake flags are registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == DONE);
        end
    end

    // Operand capture, accumulator update and bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r   <= 32'h0000_0000;
            acc_r <= 32'h0000_0000;
            cnt_r <= 3'd0;
        end else if (accept_s) begin
            x_r   <= in_data;
            acc_r <= 32'h0000_0000;
            cnt_r <= 3'd7;
        end else if (step_s) begin
            acc_r <= nxt_s;
            cnt_r <= cnt_r - 3'd1;
        end else begin
            x_r   <= x_r;
            acc_r <= acc_r;
            cnt_r <= cnt_r;
        end
    end

    // Per row: double the accumulator, add every x_j whose coefficient has bit cnt set
    for (genvar i = 0; i < 4; i++) begin : g_row
        elem_t       dbl_s;
        elem_t [3:0] sel_s;

        mul2 u_mul2 (
            .a (acc_r[i]),
            .y (dbl_s)
        );

        for (genvar j = 0; j < 4; j++) begin : g_col
            localparam elem_t COEF = MATRIX[8*(4*i+j) +: 8];
            assign sel_s[j] = COEF[cnt_r] ? x_r[j] : 8'h00;
        end

        assign nxt_s[i] = dbl_s ^ sel_s[0] ^ sel_s[1] ^ sel_s[2] ^ sel_s[3];
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = acc_r;

endmodule

// File: tb/tb_mds_serial_mix.sv
// Randomised self-checking bench: three instances (default, identity, zero
// matrix) share stimulus and are compared every cycle with a GF(2^8)-ring model.
module tb_mds_serial_mix;

    localparam logic [127:0] M_DEF  = 128'h02010103_03020101_01030201_01010302;
    localparam logic [127:0] M_ID   = 128'h01000000_00010000_00000100_00000001;
    localparam logic [127:0] M_ZERO = 128'h0;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_data;
    logic        rdy_d, rdy_i, rdy_z;
    logic        val_d, val_i, val_z;
    logic [31:0] dat_d, dat_i, dat_z;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;
    int acc_q[$];

    // behavioural model state
    bit          m_idle = 1'b1;
    bit          m_done = 1'b0;
    int          m_cnt  = 0;
    logic [31:0] e_d = 32'h0, e_i = 32'h0, e_z = 32'h0;
    logic [31:0] l_d = 32'h0, l_i = 32'h0, l_z = 32'h0;

    mds_serial_mix #(.MATRIX(M_DEF)) dut_def (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_d), .in_data(in_data),
        .out_valid(val_d), .out_ready(out_ready), .out_data(dat_d));
    mds_serial_mix #(.MATRIX(M_ID)) dut_id (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_i), .in_data(in_data),
        .out_valid(val_i), .out_ready(out_ready), .out_data(dat_i));
    mds_serial_mix #(.MATRIX(M_ZERO)) dut_zero (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_z), .in_data(in_data),
        .out_valid(val_z), .out_ready(out_ready), .out_data(dat_z));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // full ring product by shift-and-add over the bits of b
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h05 : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] mvmul(input logic [127:0] m, input logic [31:0] x);
        logic [31:0] y;
        y = 32'h0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                y[8*i +: 8] = y[8*i +: 8] ^ gmul(m[8*(4*i+j) +: 8], x[8*j +: 8]);
        return y;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h, expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // transaction-level model: accept in idle, result 8 edges later, held until taken
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_idle <= 1'b1;
            m_done <= 1'b0;
            l_d <= 32'h0; l_i <= 32'h0; l_z <= 32'h0;
        end else if (m_idle) begin
            if (in_valid) begin
                m_idle <= 1'b0;
                m_cnt  <= 0;
                e_d <= mvmul(M_DEF, in_data);
                e_i <= mvmul(M_ID, in_data);
                e_z <= mvmul(M_ZERO, in_data);
            end
        end else if (!m_done) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 7) m_done <= 1'b1;
        end else if (out_ready) begin
            m_done <= 1'b0;
            m_idle <= 1'b1;
            l_d <= e_d; l_i <= e_i; l_z <= e_z;
        end
    end

    // per-cycle comparison of all three instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready_def",  {31'd0, rdy_d}, {31'd0, m_idle});
            check("in_ready_id",   {31'd0, rdy_i}, {31'd0, m_idle});
            check("in_ready_zero", {31'd0, rdy_z}, {31'd0, m_idle});
            check("out_valid_def",  {31'd0, val_d}, {31'd0, m_done});
            check("out_valid_id",   {31'd0, val_i}, {31'd0, m_done});
            check("out_valid_zero", {31'd0, val_z}, {31'd0, m_done});
            if (m_done) begin
                check("data_def",  dat_d, e_d);
                check("data_id",   dat_i, e_i);
                check("data_zero", dat_z, e_z);
            end else if (m_idle) begin
                check("held_def",  dat_d, l_d);
                check("held_id",   dat_i, l_i);
                check("held_zero", dat_z, l_z);
            end
            if (in_valid && rdy_d && !rst) acc_q.push_back(cyc);
        end
    end

    task automatic wait_valid(output int n);
        n = 0;
        @(negedge clk);
        while (!val_d && n < 30) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_vec(input logic [31:0] x, input logic [31:0] want);
        int n;
        @(posedge clk); #2;
        in_valid = 1'b1; in_data = x; out_ready = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0; in_data = $urandom;
        wait_valid(n);
        check("latency", 32'(n), 32'd8);
        check("vec_literal", dat_d, want);
        check("vec_identity", dat_i, x);
        @(posedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          q0;
        logic [31:0] hold;
        rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0; chk_en = 1'b1;
        @(negedge clk);
        check("reset_out_data", dat_d, 32'h0);
        check("reset_in_ready", {31'd0, rdy_d}, 32'd1);
        check("reset_out_valid", {31'd0, val_d}, 32'd0);

        run_vec(32'h01010101, 32'h01010101);
        run_vec(32'h00000080, 32'h85808005);
        run_vec(32'h000000FF, 32'h04FFFFFB);
        run_vec(32'h00000000, 32'h00000000);

        // backpressure with noisy inputs while the result waits
        @(posedge clk); #2;
        in_valid = 1'b1; in_data = 32'h12345678; out_ready = 1'b0;
        @(posedge clk); #2;
        in_valid = 1'b0;
        wait_valid(n);
        check("bp_latency", 32'(n), 32'd8);
        hold = dat_d;
        repeat (20) begin
            @(posedge clk); #2;
            in_valid = 1'($urandom); in_data = $urandom;
        end
        @(negedge clk);
        check("bp_valid", {31'd0, val_d}, 32'd1);
        check("bp_data", dat_d, hold);
        check("bp_ready", {31'd0, rdy_d}, 32'd0);
        @(posedge clk); #2;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_ready", {31'd0, rdy_d}, 32'd1);
        check("bp_release_valid", {31'd0, val_d}, 32'd0);

        // reset asserted on the 4th RUN edge
        @(posedge clk); #2;
        in_valid = 1'b1; in_data = $urandom;
        @(posedge clk); #2;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", {31'd0, rdy_d}, 32'd1);
        check("midrst_valid", {31'd0, val_d}, 32'd0);
        check("midrst_data", dat_d, 32'h0);
        run_vec(32'h00000080, 32'h85808005);

        // back-to-back vectors
        q0 = acc_q.size();
        @(posedge clk); #2;
        in_valid = 1'b1; out_ready = 1'b1; in_data = $urandom;
        repeat (30) begin
            @(posedge clk); #2;
            in_data = $urandom;
        end
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        check("b2b_count", 32'(acc_q.size() - q0), 32'd3);
        for (int k = 1; k < 3; k++) begin
            if (q0 + k < acc_q.size())
                check("b2b_spacing", 32'(acc_q[q0+k] - acc_q[q0+k-1]), 32'd10);
        end

        // random traffic
        repeat (600) begin
            @(posedge clk); #2;
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("final_idle", {31'd0, rdy_d}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
